// File: rtl/alu_serial_frontend.sv
// Serial front end for a combinational ALU: deserialises a sel/A/B frame, runs one ALU cycle, then
// serialises the result and zero flag LSB first. All outputs are registered.
module alu_serial_frontend #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ser_in,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam int N  = SEL_W + 2 * WIDTH;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, LOAD, EXEC, SHIFT} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [N-1:0]       shreg_q, shreg_d;
    logic [WIDTH:0]     res_q, res_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [SEL_W-1:0]   alu_sel_q, alu_sel_d;
    logic               ser_out_q, ser_out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            res_q     <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= '0;
            ser_out_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            res_q     <= res_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_sel_q <= alu_sel_d;
            ser_out_q <= ser_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    if (cnt_q == CW'(N - 1)) state_d = EXEC;
            EXEC:    state_d = SHIFT;
            SHIFT:   if (cnt_q == CW'(WIDTH)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Frame bits enter at the MSB so frame bit 0 ends up at shreg position 0.
    always_comb begin
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        res_d     = res_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_sel_d = alu_sel_q;
        ser_out_d = 1'b0;
        busy_d    = (state_d != IDLE);
        done_d    = (state_q == SHIFT) && (state_d == IDLE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d = {ser_in, shreg_q[N-1:1]};
                    cnt_d   = CW'(1);
                end
            end
            LOAD: begin
                shreg_d = {ser_in, shreg_q[N-1:1]};
                cnt_d   = cnt_q + CW'(1);
                if (state_d == EXEC) begin
                    alu_sel_d = shreg_d[SEL_W-1:0];
                    alu_a_d   = shreg_d[SEL_W +: WIDTH];
                    alu_b_d   = shreg_d[SEL_W+WIDTH +: WIDTH];
                end
            end
            EXEC: begin
                res_d     = {alu_zero, alu_out};
                ser_out_d = alu_out[0];
                cnt_d     = '0;
            end
            SHIFT: begin
                if (state_d == SHIFT) begin
                    cnt_d     = cnt_q + CW'(1);
                    res_d     = res_q >> 1;
                    ser_out_d = res_q[1];
                end
            end
            default: ;
        endcase
    end

    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign alu_sel = alu_sel_q;
    assign ser_out = ser_out_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_alu_serial_frontend.sv
// Bench for alu_serial_frontend with an adder as the ALU; expected frames go through a scoreboard queue.
module tb_alu_serial_frontend;

    localparam int W = 8;
    localparam int S = 3;
    localparam int N = S + 2 * W;

    typedef struct {
        logic [S-1:0] sel;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   res;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         ser_in;
    logic [W-1:0] alu_a, alu_b, alu_out;
    logic [S-1:0] alu_sel;
    logic         alu_zero;
    logic         ser_out, busy, done;

    int   n_checks;
    int   n_fail;
    exp_t sb[$];

    alu_serial_frontend #(.WIDTH(W), .SEL_W(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ser_in(ser_in),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_zero(alu_zero),
        .ser_out(ser_out), .busy(busy), .done(done)
    );

    assign alu_out  = W'(alu_a + alu_b);
    assign alu_zero = (alu_out == '0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered at cycle 0 (just after an edge); returns at cycle N+W+2, the expected done cycle.
    task automatic run_frame(input logic [S-1:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W:0] res, input bit done_at_start, input bit glitch);
        logic [N-1:0] frame;
        exp_t e;
        frame = {b, a, sel};
        e = '{sel: sel, a: a, b: b, res: res};
        sb.push_back(e);
        for (int c = 0; c <= N + W + 1; c++) begin
            if (c > 0) step();
            start  = (c == 0) || (glitch && (c == 5 || c == 25));
            ser_in = (c < N) ? frame[c] : 1'($urandom);
            if (c == 0) begin
                n_checks++;
                if ({busy, done} !== {1'b0, done_at_start}) begin
                    n_fail++;
                    $display("FAIL frame_start busy/done: got %b%b expected 0%b", busy, done, done_at_start);
                end
            end else if (c < N) begin
                n_checks++;
                if ({busy, done, ser_out} !== 3'b100) begin
                    n_fail++;
                    $display("FAIL load c=%0d busy/done/ser_out: got %b%b%b expected 100", c, busy, done, ser_out);
                end
            end else if (c == N) begin
                e = sb.pop_front();
                n_checks++;
                if ({alu_sel, alu_a, alu_b} !== {e.sel, e.a, e.b}) begin
                    n_fail++;
                    $display("FAIL exec operands: got sel=%h a=%h b=%h expected sel=%h a=%h b=%h",
                             alu_sel, alu_a, alu_b, e.sel, e.a, e.b);
                end
                n_checks++;
                if ({busy, done, ser_out} !== 3'b100) begin
                    n_fail++;
                    $display("FAIL exec busy/done/ser_out: got %b%b%b expected 100", busy, done, ser_out);
                end
            end else begin
                n_checks++;
                if ({busy, done, ser_out} !== {2'b10, e.res[c-N-1]}) begin
                    n_fail++;
                    $display("FAIL shift bit %0d busy/done/ser_out: got %b%b%b expected 10%b",
                             c - N - 1, busy, done, ser_out, e.res[c-N-1]);
                end
            end
        end
        step();
        start  = 1'b0;
        ser_in = 1'b0;
    endtask

    task automatic finish_frame(input logic [W-1:0] a_hold);
        n_checks++;
        if ({done, busy, ser_out} !== 3'b100 || alu_a !== a_hold) begin
            n_fail++;
            $display("FAIL done_cycle done/busy/ser_out a: got %b%b%b %h expected 100 %h",
                     done, busy, ser_out, alu_a, a_hold);
        end
        step();
        n_checks++;
        if ({done, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL after_done done/busy: got %b%b expected 00", done, busy);
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        ser_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({alu_a, alu_b, alu_sel, ser_out, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs: got a=%h b=%h sel=%h so=%b busy=%b done=%b expected all 0",
                     alu_a, alu_b, alu_sel, ser_out, busy, done);
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL post_reset busy/done: got %b%b expected 00", busy, done);
        end
    endtask

    task automatic test_basic();
        run_frame(3'b101, 8'h35, 8'h0A, 9'h03F, 1'b0, 1'b0);
        finish_frame(8'h35);
    endtask

    task automatic test_wrap();
        run_frame(3'b010, 8'hFF, 8'h01, 9'h100, 1'b0, 1'b0);
        finish_frame(8'hFF);
    endtask

    task automatic test_start_ignored();
        run_frame(3'b101, 8'h35, 8'h0A, 9'h03F, 1'b0, 1'b1);
        finish_frame(8'h35);
    endtask

    task automatic test_back_to_back();
        run_frame(3'b001, 8'h80, 8'h80, 9'h100, 1'b0, 1'b0);
        run_frame(3'b110, 8'h01, 8'h02, 9'h003, 1'b1, 1'b0);
        finish_frame(8'h01);
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] frame;
        frame = {8'h11, 8'h22, 3'b011};
        for (int c = 0; c < 10; c++) begin
            start  = (c == 0);
            ser_in = frame[c];
            step();
        end
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({alu_a, alu_b, alu_sel, ser_out, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset outputs: got a=%h b=%h sel=%h so=%b busy=%b done=%b expected all 0",
                     alu_a, alu_b, alu_sel, ser_out, busy, done);
        end
        step();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            ser_in = 1'($urandom);
            step();
            n_checks++;
            if ({busy, done, ser_out} !== 3'b000) begin
                n_fail++;
                $display("FAIL after_abort c=%0d busy/done/ser_out: got %b%b%b expected 000", c, busy, done, ser_out);
            end
        end
        run_frame(3'b100, 8'h35, 8'h0A, 9'h03F, 1'b0, 1'b0);
        finish_frame(8'h35);
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, sum;
        logic [S-1:0] sel;
        for (int k = 0; k < 5; k++) begin
            a   = W'($urandom);
            b   = W'($urandom);
            sel = S'($urandom);
            if (k == 0) b = W'(-a);
            sum = W'(a + b);
            run_frame(sel, a, b, {(sum == '0), sum}, 1'b0, 1'b0);
            finish_frame(a);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_wrap();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
